// File: rtl/axi_slv_wr_ctrl_if.sv
// AXI4 write-channel bundle (AW, W, B) between a master and the slave write controller.
interface axi_slv_wr_ctrl_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_slv_wr_ctrl.sv
// AXI4 slave write controller: one burst at a time, per-beat memory writes, one B response.
// Optional error checking (SLVERR, write suppression, wlast checks) under `AXI_SLV_WR_ERR_EN.
module axi_slv_wr_ctrl #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic                aclk,
  input  logic                aresetn,
  axi_slv_wr_ctrl_if.slave    axi,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [1:0]          dbg_state
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_t;

  // Handshakes are plain AXI valid/ready: a transfer happens on the rising edge where both are 1;
  // the slave only raises ready (awready, wready) or valid (bvalid) in its own state, so the three
  // are mutually exclusive, and bvalid/bid/bresp hold until bready.
  state_t              state_q, state_d;
  logic                init_q;
  logic [ADDR_W-1:0]   addr_q, addr_nx, step, wrap_mask;
  logic [7:0]          len_q, cnt_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                err_q;
  logic                aw_hs, w_hs, b_hs, last_beat, wrap_ok;
  logic                beat_bad, last_bad;

  assign axi.awready = (state_q == IDLE) && init_q;
  assign axi.wready  = (state_q == DATA);
  assign axi.bvalid  = (state_q == RESP);
  assign dbg_state   = state_q;

  assign aw_hs     = axi.awvalid && axi.awready;
  assign w_hs      = axi.wvalid && axi.wready;
  assign b_hs      = axi.bvalid && axi.bready;
  assign last_beat = (cnt_q == len_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && last_beat) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // WRAP only for legal lengths; anything else falls back to INCR
  always_comb begin
    step      = ADDR_W'(1) << size_q;
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    wrap_ok   = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    addr_nx   = addr_q + step;
    if (burst_q == 2'b00)
      addr_nx = addr_q;
    else if (burst_q == 2'b10 && wrap_ok)
      addr_nx = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
  end

`ifdef AXI_SLV_WR_ERR_EN
  assign beat_bad = (|addr_q[ADDR_W-1:MEM_AW+LSB]) || (size_q > 3'(LSB));
  assign last_bad = (axi.wlast != last_beat);
`else
  logic unused_wlast;
  assign unused_wlast = axi.wlast;
  assign beat_bad     = 1'b0;
  assign last_bad     = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_q    <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      axi.bid   <= '0;
      axi.bresp <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      init_q <= 1'b1;
      mem_we <= 1'b0;
      if (aw_hs) begin
        axi.bid   <= axi.awid;
        axi.bresp <= 2'b00;
        addr_q    <= axi.awaddr;
        len_q     <= axi.awlen;
        size_q    <= axi.awsize;
        burst_q   <= axi.awburst;
        cnt_q     <= '0;
        err_q     <= 1'b0;
      end
      if (w_hs) begin
        mem_we    <= !beat_bad;
        mem_addr  <= addr_q[MEM_AW+LSB-1:LSB];
        mem_wdata <= axi.wdata;
        mem_be    <= axi.wstrb;
        addr_q    <= addr_nx;
        cnt_q     <= cnt_q + 8'd1;
        err_q     <= err_q || beat_bad || last_bad;
        // response is decided on the final beat so bresp is stable when bvalid rises
        if (last_beat)
          axi.bresp <= (err_q || beat_bad || last_bad) ? 2'b10 : 2'b00;
      end
    end
  end
endmodule
